// File: rtl/imm_disp_collect.sv
// imm_disp_collect
//   Gathers the displacement and immediate bytes of one instruction from the
//   instruction-queue byte stream. It packs them, first byte highest, into a
//   64-bit field and holds that field until the downstream separator takes it.
//
// Ports
//   clk, reset         : clock; synchronous active-high reset
//   flush              : synchronous abort of any in-flight request
//   start_valid/ready  : request handshake
//   start_disp_bytes   : displacement length (0,1,2,4)
//   start_imm_bytes    : immediate length (0,1,2,4,6)
//   byte_valid/count   : offered byte-stream bytes (1..4); first byte in data[31:24]
//   byte_data          : offered bytes
//   byte_consumed      : bytes taken this cycle (combinational)
//   out_valid/ready    : result handshake
//   out_displace_n_imm : packed displacement then immediate, first byte in [63:56]
//   out_disp_bytes     : latched displacement length
//   out_imm_bytes      : latched immediate length
//   err_illegal        : one-cycle pulse for a rejected request
module imm_disp_collect (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        start_valid,
  output logic        start_ready,
  input  logic [3:0]  start_disp_bytes,
  input  logic [3:0]  start_imm_bytes,
  input  logic        byte_valid,
  input  logic [2:0]  byte_count,
  input  logic [31:0] byte_data,
  output logic [2:0]  byte_consumed,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_displace_n_imm,
  output logic [3:0]  out_disp_bytes,
  output logic [3:0]  out_imm_bytes,
  output logic        err_illegal
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COLLECT = 2'd1;
  localparam logic [1:0] HOLD    = 2'd2;

  logic [1:0]  state_r;
  logic [3:0]  remaining_r;
  logic [3:0]  filled_r;
  logic        accept_s;
  logic        req_ok_s;
  logic [4:0]  total_s;
  logic        offered_s;
  logic [63:0] acc_merge_s;

  function automatic logic disp_legal(input logic [3:0] len);
    case (len)
      4'd0, 4'd1, 4'd2, 4'd4: disp_legal = 1'b1;
      default:                disp_legal = 1'b0;
    endcase
  endfunction

  function automatic logic imm_legal(input logic [3:0] len);
    case (len)
      4'd0, 4'd1, 4'd2, 4'd4, 4'd6: imm_legal = 1'b1;
      default:                      imm_legal = 1'b0;
    endcase
  endfunction

  // Request handshake and legality decode.
  always_comb begin
    start_ready = 1'b0;
    if (!reset && state_r == IDLE) begin
      start_ready = 1'b1;
    end else begin
      start_ready = 1'b0;
    end
    // flush in IDLE suppresses acceptance even though start_ready is shown
    accept_s = start_valid & start_ready & ~flush;
    total_s  = {1'b0, start_disp_bytes} + {1'b0, start_imm_bytes};
    req_ok_s = disp_legal(start_disp_bytes) & imm_legal(start_imm_bytes) & (total_s <= 5'd8);
  end

  // Byte consumption: min(offered, remaining) while collecting.
  always_comb begin
    byte_consumed = 3'd0;
    offered_s     = byte_valid && (byte_count != 3'd0) && (byte_count <= 3'd4);
    if (!reset && !flush && state_r == COLLECT && offered_s) begin
      if ({1'b0, byte_count} < remaining_r) begin
        byte_consumed = byte_count;
      end else begin
        // remaining_r <= byte_count <= 4 here, so the low bits hold it
        byte_consumed = remaining_r[2:0];
      end
    end else begin
      byte_consumed = 3'd0;
    end
  end

  // Merge consumed byte k into accumulator slot filled+k.
  always_comb begin
    acc_merge_s = out_displace_n_imm;
    for (int p = 0; p < 8; p++) begin
      for (int k = 0; k < 4; k++) begin
        if ((3'(k) < byte_consumed) && (filled_r + 4'(k) == 4'(p))) begin
          acc_merge_s[63-8*p -: 8] = byte_data[31-8*k -: 8];
        end else begin
          acc_merge_s[63-8*p -: 8] = acc_merge_s[63-8*p -: 8];
        end
      end
    end
  end

  // Control FSM and output registers.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      state_r            <= IDLE;
      out_valid          <= 1'b0;
      err_illegal        <= 1'b0;
      out_displace_n_imm <= 64'd0;
      out_disp_bytes     <= 4'd0;
      out_imm_bytes      <= 4'd0;
      remaining_r        <= 4'd0;
      filled_r           <= 4'd0;
    end else begin
      err_illegal <= 1'b0;
      case (state_r)
        IDLE: begin
          if (accept_s && req_ok_s) begin
            out_disp_bytes     <= start_disp_bytes;
            out_imm_bytes      <= start_imm_bytes;
            out_displace_n_imm <= 64'd0;
            remaining_r        <= total_s[3:0];
            filled_r           <= 4'd0;
            if (total_s == 5'd0) begin
              state_r   <= HOLD;
              out_valid <= 1'b1;
            end else begin
              state_r   <= COLLECT;
              out_valid <= 1'b0;
            end
          end else if (accept_s) begin
            err_illegal <= 1'b1;
          end else begin
            state_r <= IDLE;
          end
        end
        COLLECT: begin
          out_displace_n_imm <= acc_merge_s;
          filled_r           <= filled_r + {1'b0, byte_consumed};
          remaining_r        <= remaining_r - {1'b0, byte_consumed};
          if (remaining_r == {1'b0, byte_consumed}) begin
            state_r   <= HOLD;
            out_valid <= 1'b1;
          end else begin
            state_r <= COLLECT;
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_r   <= IDLE;
            out_valid <= 1'b0;
          end else begin
            state_r <= HOLD;
          end
        end
        default: begin
          state_r   <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imm_disp_collect.sv
// Self-checking bench for imm_disp_collect: directed scenarios followed by
// randomized requests checked against a byte-list reference model.
module tb_imm_disp_collect;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        start_valid;
  logic        start_ready;
  logic [3:0]  start_disp_bytes;
  logic [3:0]  start_imm_bytes;
  logic        byte_valid;
  logic [2:0]  byte_count;
  logic [31:0] byte_data;
  logic [2:0]  byte_consumed;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_displace_n_imm;
  logic [3:0]  out_disp_bytes;
  logic [3:0]  out_imm_bytes;
  logic        err_illegal;

  int n_cmp = 0;
  int n_err = 0;

  imm_disp_collect dut (
    .clk(clk), .reset(reset), .flush(flush),
    .start_valid(start_valid), .start_ready(start_ready),
    .start_disp_bytes(start_disp_bytes), .start_imm_bytes(start_imm_bytes),
    .byte_valid(byte_valid), .byte_count(byte_count), .byte_data(byte_data),
    .byte_consumed(byte_consumed),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_displace_n_imm(out_displace_n_imm),
    .out_disp_bytes(out_disp_bytes), .out_imm_bytes(out_imm_bytes),
    .err_illegal(err_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic bv, input logic [2:0] cnt, input logic [31:0] data);
    byte_valid = bv;
    byte_count = cnt;
    byte_data  = data;
  endtask

  task automatic request(input logic [3:0] d, input logic [3:0] i);
    start_valid      = 1'b1;
    start_disp_bytes = d;
    start_imm_bytes  = i;
    #1;
    chk("req_ready", {63'd0, start_ready}, 64'd1);
    tick();
    start_valid = 1'b0;
  endtask

  // Reference: pack a byte list first-byte-highest, zero-filled below.
  function automatic logic [63:0] pack(input logic [7:0] q[$]);
    logic [63:0] v;
    v = 64'd0;
    foreach (q[j]) v = {v[55:0], q[j]};
    if (q.size() == 0) return 64'd0;
    return v << (8 * (8 - q.size()));
  endfunction

  function automatic bit legal(input int d, input int i);
    return (d inside {0, 1, 2, 4}) && (i inside {0, 1, 2, 4, 6}) && (d + i <= 8);
  endfunction

  initial begin
    logic [63:0] held;
    logic [7:0]  got[$];
    int          need;
    int          d;
    int          i;
    int          cnt;
    int          take;
    int          cyc;
    int          waits;
    logic [31:0] rd;
    logic        rbv;

    reset = 1'b1; flush = 1'b0; start_valid = 1'b0;
    start_disp_bytes = 4'd0; start_imm_bytes = 4'd0;
    offer(1'b1, 3'd4, 32'hDEADBEEF);
    out_ready = 1'b0;
    tick(); tick();
    // reset state
    chk("rst_ready", {63'd0, start_ready}, 64'd0);
    chk("rst_consumed", {61'd0, byte_consumed}, 64'd0);
    chk("rst_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_data", out_displace_n_imm, 64'd0);
    chk("rst_err", {63'd0, err_illegal}, 64'd0);
    reset = 1'b0;
    offer(1'b0, 3'd0, 32'd0);
    #1;
    chk("rst_release_ready", {63'd0, start_ready}, 64'd1);
    tick();

    // disp=4 imm=2, two 4-byte offers
    request(4'd4, 4'd2);
    offer(1'b1, 3'd4, 32'h11223344);
    #1; chk("s40_cons1", {61'd0, byte_consumed}, 64'd4);
    chk("s40_notvalid", {63'd0, out_valid}, 64'd0);
    tick();
    offer(1'b1, 3'd4, 32'h55667788);
    #1; chk("s40_cons2", {61'd0, byte_consumed}, 64'd2);
    tick();
    offer(1'b0, 3'd0, 32'd0);
    chk("s40_valid", {63'd0, out_valid}, 64'd1);
    chk("s40_data", out_displace_n_imm, 64'h1122334455660000);
    chk("s40_disp", {60'd0, out_disp_bytes}, 64'd4);
    chk("s40_imm", {60'd0, out_imm_bytes}, 64'd2);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("s40_drop", {63'd0, out_valid}, 64'd0);
    chk("s40_idle", {63'd0, start_ready}, 64'd1);

    // zero-length request
    request(4'd0, 4'd0);
    chk("s41_valid", {63'd0, out_valid}, 64'd1);
    chk("s41_data", out_displace_n_imm, 64'd0);
    chk("s41_err", {63'd0, err_illegal}, 64'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("s41_drop", {63'd0, out_valid}, 64'd0);

    // illegal disp=3
    request(4'd3, 4'd1);
    chk("s42_err", {63'd0, err_illegal}, 64'd1);
    chk("s42_ready", {63'd0, start_ready}, 64'd1);
    chk("s42_valid", {63'd0, out_valid}, 64'd0);
    tick();
    chk("s42_err_pulse", {63'd0, err_illegal}, 64'd0);
    chk("s42_valid2", {63'd0, out_valid}, 64'd0);

    // disp=1 imm=1, gaps, oversupply, held output
    request(4'd1, 4'd1);
    #1; chk("s43_gap", {61'd0, byte_consumed}, 64'd0);
    tick();
    offer(1'b1, 3'd1, 32'hAB000000);
    #1; chk("s43_c1", {61'd0, byte_consumed}, 64'd1);
    tick();
    offer(1'b0, 3'd0, 32'd0);
    tick();
    offer(1'b1, 3'd2, 32'hCDEF0000);
    #1; chk("s43_c2", {61'd0, byte_consumed}, 64'd1);
    tick();
    offer(1'b0, 3'd0, 32'd0);
    chk("s43_valid", {63'd0, out_valid}, 64'd1);
    chk("s43_data", out_displace_n_imm, 64'hABCD000000000000);
    for (int w = 0; w < 3; w++) begin
      tick();
      chk("s43_hold_valid", {63'd0, out_valid}, 64'd1);
      chk("s43_hold_data", out_displace_n_imm, 64'hABCD000000000000);
      chk("s43_hold_len", {56'd0, out_disp_bytes, out_imm_bytes}, 64'h11);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("s43_drop", {63'd0, out_valid}, 64'd0);
    chk("s43_idle", {63'd0, start_ready}, 64'd1);

    // flush mid-collect, then a fresh 2-byte request
    request(4'd4, 4'd2);
    offer(1'b1, 3'd2, 32'hA1A20000);
    #1; chk("s44_c1", {61'd0, byte_consumed}, 64'd2);
    tick();
    flush = 1'b1;
    offer(1'b1, 3'd4, 32'hC1C2C3C4);
    #1; chk("s44_flush_cons", {61'd0, byte_consumed}, 64'd0);
    tick();
    offer(1'b0, 3'd0, 32'd0);
    chk("s44_flush_idle", {63'd0, start_ready}, 64'd1);
    chk("s44_flush_valid", {63'd0, out_valid}, 64'd0);
    // flush in IDLE blocks a simultaneous (illegal) start
    start_valid = 1'b1; start_disp_bytes = 4'd3; start_imm_bytes = 4'd0;
    tick();
    start_valid = 1'b0;
    chk("s44_flush_noerr", {63'd0, err_illegal}, 64'd0);
    flush = 1'b0;
    #1;
    request(4'd2, 4'd0);
    offer(1'b1, 3'd4, 32'hB1B2B3B4);
    #1; chk("s44_c2", {61'd0, byte_consumed}, 64'd2);
    tick();
    offer(1'b0, 3'd0, 32'd0);
    chk("s44_valid", {63'd0, out_valid}, 64'd1);
    chk("s44_data", out_displace_n_imm, 64'hB1B2000000000000);

    // reset while in HOLD
    reset = 1'b1;
    offer(1'b1, 3'd2, 32'h12345678);
    #1;
    chk("s45_ready", {63'd0, start_ready}, 64'd0);
    chk("s45_cons", {61'd0, byte_consumed}, 64'd0);
    tick();
    chk("s45_valid", {63'd0, out_valid}, 64'd0);
    chk("s45_data", out_displace_n_imm, 64'd0);
    chk("s45_len", {56'd0, out_disp_bytes, out_imm_bytes}, 64'd0);
    chk("s45_err", {63'd0, err_illegal}, 64'd0);
    reset = 1'b0;
    offer(1'b0, 3'd0, 32'd0);
    #1; chk("s45_ready_after", {63'd0, start_ready}, 64'd1);

    // randomized requests against the byte-list model
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 4) == 0) begin
        d = $urandom_range(0, 15);
        i = $urandom_range(0, 15);
      end else begin
        d = $urandom_range(0, 3);
        if (d == 3) d = 4;
        i = $urandom_range(0, 4);
        if (i == 3) i = 4;
        if (i == 4 && $urandom_range(0, 1) == 1) i = 6;
      end
      request(4'(d), 4'(i));
      if (!legal(d, i)) begin
        chk("rnd_err", {63'd0, err_illegal}, 64'd1);
        chk("rnd_err_valid", {63'd0, out_valid}, 64'd0);
        tick();
        chk("rnd_err_pulse", {63'd0, err_illegal}, 64'd0);
        continue;
      end
      chk("rnd_noerr", {63'd0, err_illegal}, 64'd0);
      got.delete();
      need = d + i;
      cyc  = 0;
      while (need > 0 && cyc < 60) begin
        rbv = ($urandom_range(0, 3) != 0);
        cnt = $urandom_range(0, 7);
        rd  = $urandom;
        offer(rbv, 3'(cnt), rd);
        take = (rbv && cnt >= 1 && cnt <= 4) ? ((cnt < need) ? cnt : need) : 0;
        #1;
        chk("rnd_cons", {61'd0, byte_consumed}, 64'(take));
        chk("rnd_busy_valid", {63'd0, out_valid}, 64'd0);
        for (int k = 0; k < take; k++) got.push_back(rd[31-8*k -: 8]);
        need -= take;
        cyc++;
        tick();
      end
      offer(1'b0, 3'd0, 32'd0);
      chk("rnd_collect_done", 64'(need), 64'd0);
      held = pack(got);
      chk("rnd_valid", {63'd0, out_valid}, 64'd1);
      chk("rnd_data", out_displace_n_imm, held);
      chk("rnd_len", {56'd0, out_disp_bytes, out_imm_bytes}, {56'd0, 4'(d), 4'(i)});
      waits = $urandom_range(0, 3);
      for (int w = 0; w < waits; w++) begin
        tick();
        chk("rnd_hold", out_displace_n_imm, held);
        chk("rnd_hold_valid", {63'd0, out_valid}, 64'd1);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("rnd_drop", {63'd0, out_valid}, 64'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/imm_disp_collect.md
IMM_DISP_COLLECT -- requirements
Module: imm_disp_collect

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed as listed below.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port flush, input, 1 bit: synchronous abort of any in-flight request.
REQ-005 The block SHALL have port start_valid, input, 1 bit: a new request is present.
REQ-006 The block SHALL have port start_ready, output, 1 bit: the block can accept a request.
REQ-007 The block SHALL have port start_disp_bytes, input, 4 bits: displacement length; legal values are 0, 1, 2, 4.
REQ-008 The block SHALL have port start_imm_bytes, input, 4 bits: immediate length; legal values are 0, 1, 2, 4, 6.
REQ-009 The block SHALL have port byte_valid, input, 1 bit: instruction-queue bytes are offered.
REQ-010 The block SHALL have port byte_count, input, 3 bits: number of offered bytes, 1..4.
REQ-011 The block SHALL have port byte_data, input, 32 bits: offered bytes; the first byte is in [31:24].
REQ-012 The block SHALL have port byte_consumed, output, 3 bits: bytes taken this cycle (combinational).
REQ-013 The block SHALL have port out_valid, output, 1 bit: the packed field is ready.
REQ-014 The block SHALL have port out_ready, input, 1 bit: the downstream separator accepts the field.
REQ-015 The block SHALL have port out_displace_n_imm, output, 64 bits: displacement bytes followed by immediate bytes, first byte in [63:56].
REQ-016 The block SHALL have port out_disp_bytes, output, 4 bits: latched displacement length.
REQ-017 The block SHALL have port out_imm_bytes, output, 4 bits: latched immediate length.
REQ-018 The block SHALL have port err_illegal, output, 1 bit: one-cycle pulse flagging a rejected request.

Function
REQ-019 The block SHALL implement an FSM with states IDLE, COLLECT and HOLD.
REQ-020 start_ready SHALL be 1 only in IDLE; a request is accepted on the cycle where start_valid and start_ready are both 1.
REQ-021 An accepted request with an illegal length, or with disp+imm > 8, SHALL pulse err_illegal the next cycle and leave the FSM in IDLE.
REQ-022 An accepted legal request SHALL latch both lengths, zero the 64-bit accumulator, and set remaining = disp+imm and filled = 0.
REQ-023 If disp+imm = 0, the FSM SHALL go to HOLD; otherwise it SHALL go to COLLECT.
REQ-024 In COLLECT with byte_valid = 1, byte_consumed SHALL equal min(byte_count, remaining); in all other cases it SHALL be 0.
REQ-025 Consumed byte k (k = 0 for byte_data[31:24]) SHALL be written to accumulator bits [63-8*(filled+k) -: 8]; filled SHALL increase and remaining SHALL decrease by byte_consumed.
REQ-026 Bytes offered beyond remaining SHALL NOT be consumed or written.
REQ-027 When remaining reaches 0, the FSM SHALL enter HOLD on the next edge, and out_valid SHALL be 1 from that cycle.
REQ-028 In HOLD, all out_* signals SHALL remain stable until out_ready = 1; that edge SHALL return the FSM to IDLE and drop out_valid.
REQ-029 Accumulator bytes beyond disp+imm SHALL read as 0.
REQ-030 Latency SHALL be as follows: request accepted at cycle T, bytes sampled from T+1, out_valid asserted the cycle after the last byte is consumed.
REQ-031 Minimum latency SHALL be 2 cycles; a zero-length request is valid at T+1.
REQ-032 byte_valid with byte_count = 0 or > 4 SHALL be treated as no bytes offered.
REQ-033 flush = 1 SHALL take priority over every other input in every state.
REQ-034 flush SHALL force IDLE, out_valid = 0 and err_illegal = 0 on the next edge, discarding any partial accumulation.
REQ-035 flush in IDLE SHALL suppress acceptance of a simultaneous start.

Reset
REQ-036 While reset = 1, the next edge SHALL force state IDLE and clear the following: out_valid, err_illegal, out_displace_n_imm, out_disp_bytes, out_imm_bytes, remaining, filled.
REQ-037 During reset, start_ready SHALL be 0 and byte_consumed SHALL be 0.
REQ-038 reset SHALL have priority over flush.
REQ-039 Reset asserted mid-COLLECT or in HOLD SHALL discard the request with no output pulse.

Verification
REQ-040 Scenario: disp = 4, imm = 2; bytes 11 22 33 44 offered at T+1, then 55 66 77 88 (byte_count = 4) at T+2.
Required response: byte_consumed = 4, then 2; out_valid at T+3; out_displace_n_imm = 0x1122334455660000.
REQ-041 Scenario: disp = 0, imm = 0.
Required response: out_valid at T+1 with data 0; err_illegal stays 0.
REQ-042 Scenario: disp = 3, imm = 1.
Required response: err_illegal pulses 1 cycle; start_ready stays 1; out_valid stays 0.
REQ-043 Scenario: disp = 1, imm = 1, one byte per cycle with byte_valid gaps; out_ready held 0 for 3 cycles in HOLD.
Required response: out_valid and data are held stable; the FSM returns to IDLE 1 cycle after out_ready = 1.
REQ-044 Scenario: flush asserted in COLLECT after 2 of 6 bytes, then a new request with disp = 2, imm = 0.
Required response: the new result contains only the new bytes; the lower bytes are 0.
REQ-045 Scenario: reset asserted in HOLD.
Required response: out_valid = 0 and all outputs are 0 on the next cycle; start_ready = 1 after reset deasserts.
